// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared control codes, FSM states and hazard helpers
// for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

    typedef logic [1:0] ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = 2'd0;
    localparam ctrl_t CTRL_BLOCK   = 2'd1;
    localparam ctrl_t CTRL_BUBBLE  = 2'd2;

    typedef enum logic {
        PHC_RUN     = 1'b0,
        PHC_MC_WAIT = 1'b1
    } phc_state_t;

    function automatic logic load_use(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use1,
        input logic       use2,
        input logic [4:0] rd,
        input logic       wreg,
        input logic       is_load
    );
        logic hit1;
        logic hit2;
        hit1 = use1 && (rs1 == rd);
        hit2 = use2 && (rs2 == rd);
        return is_load && wreg && (rd != 5'd0) && (hit1 || hit2);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous
// active-high reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall, bubble and flush
// codes for every pipeline register, plus perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_wreg_i,
    input  logic             ex_is_load_i,
    input  logic             ex_branch_taken_i,
    input  logic             ex_mc_start_i,
    input  logic             ex_mc_done_i,
    input  logic             mem_wait_i,
    output logic [1:0]       pc_ctrl_o,
    output logic [1:0]       if_id_ctrl_o,
    output logic [1:0]       id_ex_ctrl_o,
    output logic [1:0]       ex_mem_ctrl_o,
    output logic [1:0]       mem_wb_ctrl_o,
    output logic             mc_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(MC_TIMEOUT - 1);

    phc_state_t    state_q;
    phc_state_t    state_d;
    logic [TW-1:0] tmo_cnt_q;
    logic          tmo_set;
    logic          lu;
    logic          mc_busy;
    logic          sel_mw;
    logic          sel_mc;
    logic          sel_br;
    logic          sel_lu;
    logic          stall_inc;

    assign lu = load_use(id_rs1_addr_i, id_rs2_addr_i,
                         id_use_rs1_i, id_use_rs2_i,
                         ex_rd_addr_i, ex_wreg_i, ex_is_load_i);

    assign mc_busy = (state_q == PHC_MC_WAIT)
                   ? !ex_mc_done_i
                   : (ex_mc_start_i && !ex_mc_done_i);

    // Mutually exclusive selects encode the priority order.
    assign sel_mw = !rst && mem_wait_i;
    assign sel_mc = !rst && !mem_wait_i && mc_busy;
    assign sel_br = !rst && !mem_wait_i && !mc_busy
                  && ex_branch_taken_i;
    assign sel_lu = !rst && !mem_wait_i && !mc_busy
                  && !ex_branch_taken_i && lu;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PHC_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmo_set = 1'b0;
        unique case (state_q)
            PHC_RUN: begin
                if (!mem_wait_i && ex_mc_start_i && !ex_mc_done_i) begin
                    state_d = PHC_MC_WAIT;
                end
            end
            PHC_MC_WAIT: begin
                if (!mem_wait_i) begin
                    if (ex_mc_done_i) begin
                        state_d = PHC_RUN;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        state_d = PHC_RUN;
                        tmo_set = 1'b1;
                    end
                end
            end
            default: state_d = PHC_RUN;
        endcase
    end

    always_comb begin
        pc_ctrl_o     = CTRL_DEFAULT;
        if_id_ctrl_o  = CTRL_DEFAULT;
        id_ex_ctrl_o  = CTRL_DEFAULT;
        ex_mem_ctrl_o = CTRL_DEFAULT;
        mem_wb_ctrl_o = CTRL_DEFAULT;
        unique case (1'b1)
            sel_mw: begin
                pc_ctrl_o     = CTRL_BLOCK;
                if_id_ctrl_o  = CTRL_BLOCK;
                id_ex_ctrl_o  = CTRL_BLOCK;
                ex_mem_ctrl_o = CTRL_BLOCK;
                mem_wb_ctrl_o = CTRL_BUBBLE;
            end
            sel_mc: begin
                pc_ctrl_o     = CTRL_BLOCK;
                if_id_ctrl_o  = CTRL_BLOCK;
                id_ex_ctrl_o  = CTRL_BLOCK;
                ex_mem_ctrl_o = CTRL_BUBBLE;
            end
            sel_br: begin
                if_id_ctrl_o  = CTRL_BUBBLE;
                id_ex_ctrl_o  = CTRL_BUBBLE;
            end
            sel_lu: begin
                pc_ctrl_o     = CTRL_BLOCK;
                if_id_ctrl_o  = CTRL_BLOCK;
                id_ex_ctrl_o  = CTRL_BUBBLE;
            end
            default: ;
        endcase
    end

    // Counter keeps running under mem_wait but parks at its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if (state_q == PHC_RUN && state_d == PHC_MC_WAIT) begin
            tmo_cnt_q <= '0;
        end else if (state_q == PHC_MC_WAIT && tmo_cnt_q != TMO_LAST) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mc_timeout_o <= 1'b0;
        end else if (tmo_set) begin
            mc_timeout_o <= 1'b1;
        end
    end

    assign stall_inc = (pc_ctrl_o == CTRL_BLOCK)
                    || (if_id_ctrl_o == CTRL_BLOCK)
                    || (id_ex_ctrl_o == CTRL_BLOCK)
                    || (ex_mem_ctrl_o == CTRL_BLOCK)
                    || (mem_wb_ctrl_o == CTRL_BLOCK);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (sel_br),
        .cnt (flush_cnt_o)
    );

endmodule
